// File: rtl/fetch_responder.sv
// Instruction-side fetch responder: word-addressed store, fixed-latency valid/ready fetch, flush and loader port.
// Optional misaligned-fetch checking is enabled by defining FETCH_RSP_MISALIGN_CHK_EN.
module fetch_responder #(
   parameter int unsigned N       = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic [31:0]   req_addr,
   output logic          req_ready,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_instr,
   output logic [31:0]   rsp_addr,
   output logic          rsp_err,
   input  logic          flush,
   output logic          busy,
   input  logic          ld_we,
   input  logic [N-1:0]  ld_addr,
   input  logic [31:0]   ld_data
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 1 << N;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        instr_q, instr_d;
   logic [31:0]        raddr_q, raddr_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               busy_q, busy_d;
   logic [31:0]        cap_addr;
   logic               capture;
   logic [31:0]        mem_q [DEPTH];

`ifdef FETCH_RSP_MISALIGN_CHK_EN
   logic               err_q, err_d;
`endif

   // Instruction store: no reset, written only by the loader
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   // Next-state, countdown and response capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      raddr_d  = raddr_q;
      cap_addr = addr_q;
      capture  = 1'b0;
`ifdef FETCH_RSP_MISALIGN_CHK_EN
      err_d    = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               cap_addr = req_addr;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
                  capture = 1'b1;
               end else begin
                  cnt_d   = CNT_W'(LATENCY - 1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            end
         end
         ST_RESP: begin
            if (flush || rsp_ready) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Capture happens on the edge that enters RESP, so a same-edge loader write is not seen
      if (capture) begin
         raddr_d = cap_addr;
         instr_d = mem_q[cap_addr[N+1:2]];
`ifdef FETCH_RSP_MISALIGN_CHK_EN
         err_d   = |cap_addr[1:0];
         if (err_d) begin
            instr_d = NOP;
         end
`endif
      end

      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         instr_q     <= NOP;
         raddr_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         instr_q     <= instr_d;
         raddr_q     <= raddr_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

`ifdef FETCH_RSP_MISALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;
   assign rsp_instr = instr_q;
   assign rsp_addr  = raddr_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder (N=4 so address wrap is reachable, LATENCY=2).
module tb_fetch_responder;

   localparam int unsigned N       = 4;
   localparam int unsigned LATENCY = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [31:0]   req_addr;
   logic          req_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_instr;
   logic [31:0]   rsp_addr;
   logic          rsp_err;
   logic          flush;
   logic          busy;
   logic          ld_we;
   logic [N-1:0]  ld_addr;
   logic [31:0]   ld_data;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_responder #(.N(N), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .flush     (flush),
      .busy      (busy),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic load(input logic [N-1:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // Present one request; returns at the negedge after the acceptance edge
   task automatic present(input logic [31:0] a);
      req_valid = 1'b1; req_addr = a;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Cycles from acceptance until rsp_valid, bounded
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("consume_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int  lat;
      logic seen;
      rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (2) @(negedge clk);

      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_rsp_instr", rsp_instr,      NOP);
      check("rst_rsp_addr",  rsp_addr,       32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      rst = 1'b1;
      @(negedge clk);

      load(4'd3, 32'hDEAD_BEEF);
      load(4'd4, 32'hCAFE_0004);
      load(4'd1, 32'h1111_0001);

      // Load-then-fetch with backpressure
      present(32'h0000_000C);
      check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      check("wait_req_ready", 32'(req_ready), 32'd0);
      check("wait_busy",      32'(busy),      32'd1);
      wait_rsp(lat);
      check("latency",   32'(lat),  32'(LATENCY - 1));
      check("instr_0c",  rsp_instr, 32'hDEAD_BEEF);
      check("addr_0c",   rsp_addr,  32'h0000_000C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_instr", rsp_instr,      32'hDEAD_BEEF);
         check("bp_addr",  rsp_addr,       32'h0000_000C);
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_busy",  32'(busy),      32'd1);
      end
      consume();
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);

      // Flush in WAIT abandons the fetch
      present(32'h0000_0010);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy",  32'(busy),      32'd0);
      check("flush_valid", 32'(rsp_valid), 32'd0);
      seen = 1'b0;
      repeat (4) begin @(negedge clk); seen |= rsp_valid; end
      check("flush_no_rsp", 32'(seen), 32'd0);
      present(32'h0000_0010);
      wait_rsp(lat);
      check("lat_10",   32'(lat),  32'(LATENCY - 1));
      check("instr_10", rsp_instr, 32'hCAFE_0004);
      check("addr_10",  rsp_addr,  32'h0000_0010);
      consume();

      // Address wrap: 0x44 with N=4 maps to word 1
      present(32'h0000_0044);
      wait_rsp(lat);
      check("instr_44", rsp_instr, 32'h1111_0001);
      check("addr_44",  rsp_addr,  32'h0000_0044);
      consume();

      // Misaligned fetch
      present(32'h0000_0006);
      wait_rsp(lat);
      check("addr_06", rsp_addr, 32'h0000_0006);
`ifdef FETCH_RSP_MISALIGN_CHK_EN
      check("instr_06", rsp_instr,    NOP);
      check("err_06",   32'(rsp_err), 32'd1);
`else
      check("instr_06", rsp_instr,    32'h1111_0001);
      check("err_06",   32'(rsp_err), 32'd0);
`endif
      consume();

      // Flush together with rsp_ready in RESP
      present(32'h0000_0010);
      wait_rsp(lat);
      flush = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; rsp_ready = 1'b0;
      check("flush_resp_valid", 32'(rsp_valid), 32'd0);
      check("flush_resp_ready", 32'(req_ready), 32'd1);

      // Loader write on the capture edge returns old data
      present(32'h0000_000C);
      ld_we = 1'b1; ld_addr = 4'd3; ld_data = 32'h1234_5678;
      @(negedge clk);
      ld_we = 1'b0;
      check("race_valid", 32'(rsp_valid), 32'd1);
      check("race_old",   rsp_instr,      32'hDEAD_BEEF);
      consume();
      present(32'h0000_000C);
      wait_rsp(lat);
      check("race_new", rsp_instr, 32'h1234_5678);
      consume();

      // Reset mid-WAIT clears outputs without waiting for a clock edge
      present(32'h0000_0010);
      #1 rst = 1'b0;
      #1;
      check("arst_busy",  32'(busy),      32'd0);
      check("arst_ready", 32'(req_ready), 32'd1);
      check("arst_valid", 32'(rsp_valid), 32'd0);
      check("arst_instr", rsp_instr,      NOP);
      check("arst_addr",  rsp_addr,       32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (5) begin @(negedge clk); seen |= rsp_valid; end
      check("arst_no_rsp", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_responder.md
# fetch_responder

Instruction-side memory responder serving the core's fetch port over a valid/ready request/response handshake with a fixed, parameterised latency. It holds a word-addressed instruction store, accepts one fetch address at a time, and returns the 32-bit instruction word after `LATENCY` cycles. It supports pipeline flush of an outstanding fetch and has a side write port for program loading. It sits between the fetch stage and the instruction store, and its `busy` output feeds the hazard logic that generates the fetch stall.

## Interface
- `N`, 12, log2 of store depth in 32-bit words; the word index is `req_addr[N+1:2]`.
- `LATENCY`, 2, cycles from request acceptance to response valid; legal range 1..15.
- `clk` input 1: single clock; all logic is posedge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: a fetch request is presented.
- `req_addr` input 32: byte address of the fetch.
- `req_ready` output 1: the responder can accept a request this cycle.
- `rsp_valid` output 1: `rsp_instr`, `rsp_addr` and `rsp_err` are valid.
- `rsp_ready` input 1: the consumer takes the response this cycle.
- `rsp_instr` output 32: fetched instruction word.
- `rsp_addr` output 32: byte address of the request being answered.
- `rsp_err` output 1: misaligned-fetch indication (see Configuration).
- `flush` input 1: abandon any outstanding fetch.
- `busy` output 1: a request is in flight or a response is unconsumed.
- `ld_we` input 1: loader write enable.
- `ld_addr` input N: loader word index.
- `ld_data` input 32: loader write data.

## Operation
- FSM has three states.
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown.
  - RESP: `rsp_valid`=1.
- IDLE: `req_valid`&`req_ready` latches `req_addr`.
  - With `LATENCY`=1, go to RESP.
  - Otherwise, load the counter with `LATENCY`-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP at the next edge.
- Entering RESP: capture `mem[addr_q[N+1:2]]` into `rsp_instr`, `addr_q` into `rsp_addr`, and the error flag into `rsp_err`.
- RESP: outputs are held stable while `rsp_ready`=0.
  - On `rsp_valid`&`rsp_ready`, return to IDLE.
  - There is no request acceptance in RESP, so the minimum repeat interval is `LATENCY`+1 cycles.
- `flush`=1 in WAIT or RESP: go to IDLE at the next edge and drop `rsp_valid`.
  - The abandoned response is never presented.
  - The counter is cleared.
- `flush` in IDLE is ignored. A simultaneous `req_valid` is accepted normally.
- `flush` and `rsp_ready` together in RESP: return to IDLE. The result is identical either way.
- `busy` = (state != IDLE).
- Address bits above N+1 are ignored, so addresses wrap modulo 2^(N+2) bytes.
- Loader port: on `ld_we`, `mem[ld_addr]` <= `ld_data` at the edge.
  - It is independent of the FSM.
  - If a write and the RESP capture hit the same word in the same cycle, the capture returns the old data.
- The store has no reset. Its contents are undefined until loaded.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1, `rsp_valid`=0, `busy`=0.
  - `rsp_instr`=32'h00000013 (NOP), `rsp_addr`=0, `rsp_err`=0, counter 0.
- Reset asserted mid-fetch immediately aborts the fetch. The first acceptance is possible at the first edge after deassertion.
- Acceptance at edge k: `rsp_valid` is high in the cycle following edge k+`LATENCY`-1. For example, with `LATENCY`=2, accept at edge 0 and `rsp_valid` is high after edge 1.
- `req_ready` is a pure state decode. It does not depend combinationally on `req_valid`.
- `rsp_*` outputs are registered. No input-to-output combinational path exists.

## Configuration
- `FETCH_RSP_MISALIGN_CHK_EN` defined:
  - A request with `req_addr[1:0]`!=0 completes with normal latency.
  - It returns `rsp_err`=1 and `rsp_instr`=32'h00000013.
  - The store is not read.
- Not defined:
  - `req_addr[1:0]` is ignored.
  - `rsp_err` is tied to 0.
  - The error path logic is absent.

## Test plan
- Load-then-fetch with LATENCY=2: load word 3 with 32'hDEADBEEF, fetch 0x0C.
  - Expect `rsp_valid` one cycle after acceptance.
  - Expect `rsp_instr`=32'hDEADBEEF and `rsp_addr`=0x0C.
- Backpressure: hold `rsp_ready`=0 for 5 cycles.
  - Expect `rsp_*` stable, `req_ready`=0 and `busy`=1 throughout.
  - Release `rsp_ready`: expect IDLE next cycle.
- Flush: flush in WAIT.
  - Expect no `rsp_valid` and `busy`=0 next cycle.
  - A new fetch of 0x10 then returns word 4 correctly.
- Wrap-around with N=4: fetch 0x44.
  - Expect word 1 returned, and `rsp_addr`=0x44.
- Misaligned fetch of 0x06:
  - With the macro: `rsp_err`=1 and `rsp_instr`=32'h00000013.
  - Without the macro: word 1 is returned and `rsp_err`=0.
- Reset mid-WAIT:
  - Expect all outputs at reset values asynchronously and no later response.
  - Same-cycle loader write to a word under RESP capture returns the old value.
